// File: rtl/processor_debug_pkg.sv
// Shared types and constants for the host-side processor debug controller.
package processor_debug_pkg;

  typedef enum logic [1:0] {
    DBG_STATUS      = 2'd0,
    DBG_READ_REG    = 2'd1,
    DBG_CONTINUE    = 2'd2,
    DBG_RUN_TO_WAIT = 2'd3
  } dbg_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN,
    ST_PULSE,
    ST_GAP,
    ST_RESP
  } dbg_state_e;

  localparam logic [3:0] DBG_REG_IP = 4'd8;

endpackage

// File: rtl/processor_debug_host_sat_counter.sv
// Clear/enable counter that sticks at all-ones instead of wrapping.
module debug_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/processor_debug_host.sv
// Host-side sequencer for the processor wait/continue and debug-register
// readout; one response word per accepted command.
module processor_debug_host
  import processor_debug_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = 18,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned CYCLE_CNT_SIZE = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [3:0]           cmd_reg,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_error,
  input  logic                 wait_for_continue,
  output logic                 wait_continue_execution,
  output logic                 debug_get_param,
  output logic [3:0]           debug_reg_addr,
  input  logic [WORD_SIZE-1:0] debug_data_out
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  dbg_state_e state, state_next;

  logic                      accept;
  logic [3:0]                reg_q;
  logic [WORD_SIZE-1:0]      rsp_data_q, rsp_data_d;
  logic                      rsp_error_q, rsp_error_d;
  logic                      rsp_load;
  logic [SETTLE_W-1:0]       settle_cnt;
  logic [CYCLE_CNT_SIZE-1:0] run_cnt;
  logic [WORD_SIZE-1:0]      run_word;

  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;

  debug_sat_counter #(.WIDTH(SETTLE_W)) u_settle_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable (state == ST_SETTLE),
    .count  (settle_cnt)
  );

  debug_sat_counter #(.WIDTH(CYCLE_CNT_SIZE)) u_run_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable ((state == ST_RUN) && !wait_for_continue),
    .count  (run_cnt)
  );

  generate
    if (CYCLE_CNT_SIZE >= WORD_SIZE) begin : g_run_trunc
      assign run_word = run_cnt[WORD_SIZE-1:0];
    end else begin : g_run_zext
      assign run_word = {{(WORD_SIZE - CYCLE_CNT_SIZE){1'b0}}, run_cnt};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      reg_q       <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      if (accept) begin
        reg_q <= cmd_reg;
      end
      if (rsp_load) begin
        rsp_data_q  <= rsp_data_d;
        rsp_error_q <= rsp_error_d;
      end
    end
  end

  // The op decision is made at acceptance, so later states only need reg_q.
  always_comb begin
    state_next              = state;
    rsp_load                = 1'b0;
    rsp_data_d              = '0;
    rsp_error_d             = 1'b0;
    rsp_valid               = (state == ST_RESP);
    wait_continue_execution = (state == ST_PULSE);
    debug_get_param         = (state == ST_SETTLE);
    debug_reg_addr          = (state == ST_SETTLE) ? reg_q : '0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          rsp_load = 1'b1;
          case (dbg_op_e'(cmd_op))
            DBG_STATUS: begin
              state_next = ST_RESP;
              rsp_data_d = WORD_SIZE'(wait_for_continue);
            end
            DBG_READ_REG: begin
              if (wait_for_continue && (cmd_reg <= DBG_REG_IP)) begin
                state_next = ST_SETTLE;
              end else begin
                state_next  = ST_RESP;
                rsp_error_d = 1'b1;
              end
            end
            DBG_CONTINUE: begin
              if (wait_for_continue) begin
                state_next = ST_PULSE;
              end else begin
                state_next  = ST_RESP;
                rsp_error_d = 1'b1;
              end
            end
            default: state_next = ST_RUN;
          endcase
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          rsp_load   = 1'b1;
          rsp_data_d = debug_data_out;
          state_next = ST_RESP;
        end
      end
      ST_RUN: begin
        if (wait_for_continue) begin
          rsp_load   = 1'b1;
          rsp_data_d = run_word;
          state_next = ST_RESP;
        end
      end
      ST_PULSE: state_next = ST_GAP;
      ST_GAP:   state_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_processor_debug_host.sv
// Directed bench for processor_debug_host with a small register-file model.
module tb_processor_debug_host;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_reg;
  logic        rsp_valid, rsp_ready;
  logic [17:0] rsp_data;
  logic        rsp_error;
  logic        wait_for_continue;
  logic        wait_continue_execution;
  logic        debug_get_param;
  logic [3:0]  debug_reg_addr;
  logic [17:0] debug_data_out;

  logic        s_cmd_valid, s_cmd_ready, s_rsp_valid, s_rsp_error, s_wait;
  logic [17:0] s_rsp_data;
  logic        s_wce, s_gp;
  logic [3:0]  s_addr;
  logic [17:0] s_dbg_data = 18'h0;

  logic [17:0] regs [0:8];
  int tests = 0;
  int failed = 0;
  int gp_cycles = 0;
  int wce_cycles = 0;
  int both_cycles = 0;
  logic [3:0] gp_addr = '0;
  int lat, snap;

  always #5 clock = ~clock;

  processor_debug_host #(.WORD_SIZE(18), .SETTLE_CYCLES(2), .CYCLE_CNT_SIZE(18)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_reg(cmd_reg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .wait_for_continue(wait_for_continue), .wait_continue_execution(wait_continue_execution),
    .debug_get_param(debug_get_param), .debug_reg_addr(debug_reg_addr),
    .debug_data_out(debug_data_out)
  );

  processor_debug_host #(.WORD_SIZE(18), .SETTLE_CYCLES(2), .CYCLE_CNT_SIZE(4)) dut_sat (
    .clock(clock), .reset(reset),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(2'd3), .cmd_reg(4'd0),
    .rsp_valid(s_rsp_valid), .rsp_ready(1'b0), .rsp_data(s_rsp_data), .rsp_error(s_rsp_error),
    .wait_for_continue(s_wait), .wait_continue_execution(s_wce),
    .debug_get_param(s_gp), .debug_reg_addr(s_addr),
    .debug_data_out(s_dbg_data)
  );

  // Readout is only valid while the processor is frozen for debug.
  assign debug_data_out = (debug_get_param && debug_reg_addr <= 4'd8) ? regs[debug_reg_addr] : 18'h0;

  always @(negedge clock) begin
    if (debug_get_param) begin
      gp_cycles++;
      gp_addr = debug_reg_addr;
    end
    if (wait_continue_execution) wce_cycles++;
    if (debug_get_param && wait_continue_execution) both_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one command, then returns cycles from acceptance to rsp_valid.
  task automatic issue(input logic [1:0] op, input logic [3:0] r, output int l);
    cmd_op = op;
    cmd_reg = r;
    cmd_valid = 1'b1;
    check("issue_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_reg = 4'd0;
    l = 1;
    while (!rsp_valid && l < 200) begin
      tick();
      l++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_hs_rsp_valid", rsp_valid, 0);
    check("post_hs_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 9; i++) regs[i] = 18'(18'h01000 + i);
    regs[0] = 18'h00111;
    regs[3] = 18'h2A5A;
    regs[8] = 18'h3F0F0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_reg = 4'd0;
    rsp_ready = 1'b0; wait_for_continue = 1'b1;
    s_cmd_valid = 1'b0; s_wait = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_wce", wait_continue_execution, 0);
    check("rst_gp", debug_get_param, 0);
    check("rst_addr", debug_reg_addr, 0);
    reset = 1'b0;
    #1;
    check("idle_cmd_ready", cmd_ready, 1);

    // STATUS while halted
    issue(2'd0, 4'd0, lat);
    check("status_lat", lat, 1);
    check("status_data", rsp_data, 1);
    check("status_err", rsp_error, 0);
    finish_rsp();

    // READ_REG r3 while halted
    snap = gp_cycles;
    issue(2'd1, 4'd3, lat);
    check("rd3_lat", lat, 3);
    check("rd3_data", rsp_data, 18'h2A5A);
    check("rd3_err", rsp_error, 0);
    check("rd3_gp_cycles", gp_cycles - snap, 2);
    check("rd3_gp_addr", gp_addr, 3);
    check("rd3_gp_low_in_resp", debug_get_param, 0);
    finish_rsp();

    // READ_REG ip (boundary index 8) and index 9 (rejected)
    issue(2'd1, 4'd8, lat);
    check("rdip_lat", lat, 3);
    check("rdip_data", rsp_data, 18'h3F0F0);
    check("rdip_err", rsp_error, 0);
    finish_rsp();
    snap = gp_cycles;
    issue(2'd1, 4'd9, lat);
    check("rd9_lat", lat, 1);
    check("rd9_err", rsp_error, 1);
    check("rd9_data", rsp_data, 0);
    check("rd9_no_gp", gp_cycles - snap, 0);
    finish_rsp();

    // READ_REG while running
    wait_for_continue = 1'b0;
    snap = gp_cycles;
    issue(2'd1, 4'd0, lat);
    check("rdrun_lat", lat, 1);
    check("rdrun_err", rsp_error, 1);
    check("rdrun_data", rsp_data, 0);
    check("rdrun_no_gp", gp_cycles - snap, 0);
    finish_rsp();

    // CONTINUE halted, then CONTINUE running
    wait_for_continue = 1'b1;
    snap = wce_cycles;
    issue(2'd2, 4'd0, lat);
    check("cont_lat", lat, 3);
    check("cont_err", rsp_error, 0);
    check("cont_data", rsp_data, 0);
    check("cont_one_pulse", wce_cycles - snap, 1);
    finish_rsp();
    wait_for_continue = 1'b0;
    snap = wce_cycles;
    issue(2'd2, 4'd0, lat);
    check("cont2_lat", lat, 1);
    check("cont2_err", rsp_error, 1);
    check("cont2_no_pulse", wce_cycles - snap, 0);
    finish_rsp();

    // STATUS while running
    issue(2'd0, 4'd0, lat);
    check("status_run_data", rsp_data, 0);
    finish_rsp();

    // RUN_TO_WAIT: processor stays running 100 cycles after acceptance
    cmd_op = 2'd3;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    check("run_still_busy", rsp_valid, 0);
    check("run_cmd_ready", cmd_ready, 0);
    wait_for_continue = 1'b1;
    tick();
    check("run_rsp_valid", rsp_valid, 1);
    check("run_data", rsp_data, 100);
    check("run_err", rsp_error, 0);
    finish_rsp();

    // RUN_TO_WAIT when already halted
    issue(2'd3, 4'd0, lat);
    check("run0_lat", lat, 2);
    check("run0_data", rsp_data, 0);
    finish_rsp();

    // Saturating 4-bit counter instance, 40-cycle run
    s_cmd_valid = 1'b1;
    tick();
    s_cmd_valid = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    s_wait = 1'b1;
    tick();
    check("sat_rsp_valid", s_rsp_valid, 1);
    check("sat_data", s_rsp_data, 15);

    // Backpressure on the response with a pending command
    issue(2'd0, 4'd0, lat);
    check("bp_first_valid", rsp_valid, 1);
    cmd_op = 2'd1;
    cmd_reg = 4'd3;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 1);
      check("bp_err", rsp_error, 0);
      check("bp_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_hs_valid", rsp_valid, 0);
    check("bp_hs_cmd_ready", cmd_ready, 1);
    check("bp_hs_not_accepted", debug_get_param, 0);
    tick();
    cmd_valid = 1'b0;
    check("bp_accept_gp", debug_get_param, 1);
    check("bp_accept_addr", debug_reg_addr, 3);

    // Reset during SETTLE aborts without a response
    reset = 1'b1;
    tick();
    check("abort_gp", debug_get_param, 0);
    check("abort_addr", debug_reg_addr, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_cmd_ready", cmd_ready, 0);
    check("abort_wce", wait_continue_execution, 0);
    check("abort_rsp_data", rsp_data, 0);
    reset = 1'b0;
    snap = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid) snap++;
    end
    check("abort_no_rsp", snap, 0);
    wait_for_continue = 1'b0;
    issue(2'd0, 4'd0, lat);
    check("after_abort_status0", rsp_data, 0);
    finish_rsp();
    wait_for_continue = 1'b1;
    issue(2'd0, 4'd0, lat);
    check("after_abort_status1", rsp_data, 1);
    finish_rsp();

    check("never_gp_and_wce", both_cycles, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
